alert_status_uart_tx: RTL



---
 rtl/alert_link_pkg.sv | 27 ++
 rtl/uart_tx_byte.sv | 71 +++++++
 rtl/alert_status_uart_tx.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/alert_link_pkg.sv
// Shared definitions for the FPGA -> ESP32 alert status link:
// frame constants, status bit positions, FSM encoding and checksum helper.
package alert_link_pkg;

    localparam logic [7:0]  SYNC_BYTE   = 8'hA5;
    localparam int unsigned FRAME_BYTES = 4;

    // Bit positions inside the status byte
    localparam int unsigned ST_ALERT  = 0;
    localparam int unsigned ST_FFT    = 1;
    localparam int unsigned ST_CAM    = 2;
    localparam int unsigned ST_CHANGE = 3;

    // Frame FSM encoding (kept as plain constants for legacy tooling)
    typedef logic [1:0] link_state_t;
    localparam link_state_t S_IDLE = 2'd0;
    localparam link_state_t S_LOAD = 2'd1;
    localparam link_state_t S_SEND = 2'd2;
    localparam link_state_t S_DONE = 2'd3;

    // Checksum byte: XOR of sync, status and sequence bytes
    function automatic logic [7:0] frame_checksum(input logic [7:0] status,
                                                  input logic [7:0] seq);
        return SYNC_BYTE ^ status ^ seq;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 UART serialiser, LSB first, idle high.
// ready is also high during the final cycle of the stop bit so a new byte
// can follow with no idle gap; byte_done flags that same final cycle.
module uart_tx_byte
    import alert_link_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready,
    output logic       byte_done
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    STOP_IDX = 4'd9;

    logic          active_q;
    logic [CW-1:0] clk_cnt_q;
    logic [3:0]    bit_idx_q;
    logic [8:0]    shift_q;
    logic          tx_q;
    logic          bit_last;
    logic          stop_end;

    // Decode end of the current bit and end of the stop bit
    always_comb begin
        bit_last  = (clk_cnt_q == CLK_LAST);
        stop_end  = active_q && (bit_idx_q == STOP_IDX) && bit_last;
        ready     = !active_q || stop_end;
        byte_done = stop_end;
    end

    // Bit timing, shift register and line driver
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q  <= 1'b0;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '1;
            tx_q      <= 1'b1;
        end else if (start && ready) begin
            active_q  <= 1'b1;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= {1'b1, data};
            tx_q      <= 1'b0;
        end else if (active_q) begin
            if (bit_last) begin
                clk_cnt_q <= '0;
                if (bit_idx_q == STOP_IDX) begin
                    active_q <= 1'b0;
                    tx_q     <= 1'b1;
                end else begin
                    bit_idx_q <= bit_idx_q + 4'd1;
                    tx_q      <= shift_q[0];
                    shift_q   <= {1'b1, shift_q[8:1]};
                end
            end else begin
                clk_cnt_q <= clk_cnt_q + CW'(1);
            end
        end
    end

    assign tx = tx_q;

endmodule

// File: rtl/alert_status_uart_tx.sv
// Alert status return link: detects alert changes and heartbeat timeouts,
// builds 4-byte checksummed frames {A5, status, seq, xor} and sends them
// over an 8N1 UART via uart_tx_byte.
module alert_status_uart_tx
    import alert_link_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT     = 434,
    parameter int unsigned HEARTBEAT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       alert_in,
    input  logic       fft_in,
    input  logic       cam_in,
    output logic       tx_out,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] seq_out
);

    localparam int unsigned HW = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;
    localparam logic [HW-1:0] HB_LAST   = HW'(HEARTBEAT_CYCLES - 1);
    localparam logic [1:0]    LAST_BYTE = 2'(FRAME_BYTES - 1);

    link_state_t   state_q, state_d;
    logic          alert_q;
    logic          chg_pending_q;
    logic          hb_pending_q;
    logic [HW-1:0] hb_cnt_q;
    logic [7:0]    status_q, status_d;
    logic [7:0]    seq_q;
    logic [1:0]    byte_idx_q;

    logic          alert_chg;
    logic          hb_wrap;
    logic          byte_start;
    logic [1:0]    byte_sel;
    logic [7:0]    byte_data;
    logic          tx_ready;
    logic          tx_byte_done;
    logic          last_byte_done;

    // Event decode, status snapshot value and byte selection
    always_comb begin
        alert_chg      = (alert_in != alert_q);
        hb_wrap        = (state_q == S_IDLE) && (hb_cnt_q == HB_LAST);
        last_byte_done = tx_byte_done && (byte_idx_q == LAST_BYTE);

        status_d            = '0;
        status_d[ST_ALERT]  = alert_in;
        status_d[ST_FFT]    = fft_in;
        status_d[ST_CAM]    = cam_in;
        status_d[ST_CHANGE] = chg_pending_q;

        // LOAD launches byte 0; each byte_done in SEND chains the next one
        byte_start = tx_ready &&
                     ((state_q == S_LOAD) ||
                      ((state_q == S_SEND) && tx_byte_done && (byte_idx_q != LAST_BYTE)));
        byte_sel   = (state_q == S_LOAD) ? 2'd0 : (byte_idx_q + 2'd1);

        case (byte_sel)
            2'd0:    byte_data = SYNC_BYTE;
            2'd1:    byte_data = status_q;
            2'd2:    byte_data = seq_q;
            default: byte_data = frame_checksum(status_q, seq_q);
        endcase
    end

    // Frame FSM next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (chg_pending_q || hb_pending_q) state_d = S_LOAD;
            S_LOAD:  state_d = S_SEND;
            S_SEND:  if (last_byte_done) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Alert sampling and pending-event flags; LOAD consumes both together
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alert_q       <= 1'b0;
            chg_pending_q <= 1'b0;
            hb_pending_q  <= 1'b0;
        end else begin
            alert_q <= alert_in;
            if (state_q == S_LOAD) begin
                chg_pending_q <= 1'b0;
                hb_pending_q  <= 1'b0;
            end else begin
                if (alert_chg) chg_pending_q <= 1'b1;
                if (hb_wrap)   hb_pending_q  <= 1'b1;
            end
        end
    end

    // Heartbeat counter: runs only in IDLE, held at zero otherwise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hb_cnt_q <= '0;
        end else if (state_q == S_IDLE) begin
            hb_cnt_q <= hb_wrap ? '0 : (hb_cnt_q + HW'(1));
        end else begin
            hb_cnt_q <= '0;
        end
    end

    // FSM state, status snapshot, byte index and sequence number
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            status_q   <= '0;
            seq_q      <= '0;
            byte_idx_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_LOAD: begin
                    status_q   <= status_d;
                    byte_idx_q <= '0;
                end
                S_SEND: begin
                    if (tx_byte_done && (byte_idx_q != LAST_BYTE))
                        byte_idx_q <= byte_idx_q + 2'd1;
                end
                S_DONE: seq_q <= seq_q + 8'd1;
                default: ;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (byte_start),
        .data     (byte_data),
        .tx       (tx_out),
        .ready    (tx_ready),
        .byte_done(tx_byte_done)
    );

    assign busy       = (state_q == S_LOAD) || (state_q == S_SEND);
    assign frame_done = (state_q == S_DONE);
    assign seq_out    = seq_q;

endmodule
